// File: rtl/VX_gpu_pkg.sv
// Shared constants and types for the ALU PE share arbiter slice.
//   ALU_PE_NUM_REQS      default requester count
//   ALU_PE_MAX_INFLIGHT  default outstanding-operation limit (power of 2)
//   alu_pe_req_idx_t     requester index sized for the default requester count
//   idx_bits()           index width for n entries; never narrower than 1 bit
package VX_gpu_pkg;

  localparam int unsigned ALU_PE_NUM_REQS     = 4;
  localparam int unsigned ALU_PE_MAX_INFLIGHT = 4;
  localparam int unsigned ALU_PE_REQ_IDXW     = $clog2(ALU_PE_NUM_REQS);

  typedef logic [ALU_PE_REQ_IDXW-1:0] alu_pe_req_idx_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_pe_tag_fifo.sv
// Synchronous first-word-fall-through FIFO of requester indices.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   push, din      write din when push is high and the FIFO is not full
//   pop            drop head when pop is high and the FIFO is not empty
//   head           oldest entry (valid whenever empty is low)
//   full, empty    occupancy flags
//   count          current occupancy, 0..DEPTH
module alu_pe_tag_fifo
  import VX_gpu_pkg::*;
#(
  parameter int unsigned DATAW = 2,
  parameter int unsigned DEPTH = ALU_PE_MAX_INFLIGHT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [DATAW-1:0]             din,
  input  logic                         pop,
  output logic [DATAW-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = idx_bits(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // DEPTH is a power of 2, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_pe_share_arbiter.sv
// Shares one pipelined in-order ALU PE among NUM_REQS requesters.
// Round-robin arbitration with grant locking, credit limit of MAX_INFLIGHT
// outstanding operations, and in-order response routing via a tag FIFO.
// Ports:
//   req_valid/req_data/req_ready      per-requester request channel
//   pe_req_valid/pe_req_data/pe_req_ready   request to the shared PE
//   pe_rsp_valid/pe_rsp_data/pe_rsp_ready   response from the shared PE
//   rsp_valid/rsp_data/rsp_ready      per-requester response (data broadcast)
//   inflight                          outstanding operation count
//   err                               sticky flag: response with no owner
module alu_pe_share_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int unsigned NUM_REQS     = ALU_PE_NUM_REQS,
  parameter int unsigned REQ_DATAW    = 128,
  parameter int unsigned RSP_DATAW    = 64,
  parameter int unsigned MAX_INFLIGHT = ALU_PE_MAX_INFLIGHT
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQS-1:0]                 req_valid,
  input  logic [NUM_REQS*REQ_DATAW-1:0]       req_data,
  output logic [NUM_REQS-1:0]                 req_ready,
  output logic                                pe_req_valid,
  output logic [REQ_DATAW-1:0]                pe_req_data,
  input  logic                                pe_req_ready,
  input  logic                                pe_rsp_valid,
  input  logic [RSP_DATAW-1:0]                pe_rsp_data,
  output logic                                pe_rsp_ready,
  output logic [NUM_REQS-1:0]                 rsp_valid,
  output logic [RSP_DATAW-1:0]                rsp_data,
  input  logic [NUM_REQS-1:0]                 rsp_ready,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic                                err
);

  localparam int unsigned IDXW = idx_bits(NUM_REQS);

  logic [REQ_DATAW-1:0] slice [NUM_REQS];

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_slice
    assign slice[g] = req_data[g*REQ_DATAW +: REQ_DATAW];
  end

  logic [IDXW-1:0] rr_ptr;
  logic            lock_valid;
  logic [IDXW-1:0] lock_idx;

  logic [IDXW-1:0] search_idx;
  logic [IDXW-1:0] cidx;
  int unsigned     cand;
  logic            found;
  logic [IDXW-1:0] winner;
  logic            win_valid;
  logic            issue_ok;
  logic            req_fire;
  logic [IDXW-1:0] rr_next;

  logic [IDXW-1:0] head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            rsp_fire;
  logic            pop;
  logic            spurious;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    cand       = 0;
    cidx       = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cand = (32'(rr_ptr) + i) % NUM_REQS;
      cidx = IDXW'(cand);
      if (!found && req_valid[cidx]) begin
        found      = 1'b1;
        search_idx = cidx;
      end
    end
  end

  // A locked grant bypasses the search so later arrivals cannot preempt it.
  assign winner    = lock_valid ? lock_idx : search_idx;
  assign win_valid = lock_valid ? req_valid[lock_idx] : found;
  // Credit check uses the registered count only, keeping ready off the
  // response path; issuing at the full boundary waits one cycle.
  assign issue_ok  = !fifo_full;

  assign pe_req_valid = reset_n && issue_ok && win_valid;
  assign pe_req_data  = slice[winner];
  assign req_fire     = pe_req_valid && pe_req_ready;
  assign rr_next      = (winner == IDXW'(NUM_REQS - 1)) ? '0 : winner + IDXW'(1);

  always_comb begin
    req_ready = '0;
    if (pe_req_valid && pe_req_ready) req_ready[winner] = 1'b1;
  end

  // Responses with no owner are accepted and dropped so the PE cannot stall.
  always_comb begin
    rsp_valid = '0;
    if (reset_n && !fifo_empty) rsp_valid[head] = pe_rsp_valid;
  end

  assign pe_rsp_ready = reset_n && (fifo_empty || rsp_ready[head]);
  assign rsp_data     = pe_rsp_data;
  assign rsp_fire     = pe_rsp_valid && pe_rsp_ready;
  assign pop          = rsp_fire && !fifo_empty;
  assign spurious     = rsp_fire && fifo_empty;

  alu_pe_tag_fifo #(
    .DATAW (IDXW),
    .DEPTH (MAX_INFLIGHT)
  ) tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_fire),
    .din     (winner),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (inflight)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      err        <= 1'b0;
    end else begin
      if (req_fire) rr_ptr <= rr_next;
      lock_valid <= pe_req_valid && !pe_req_ready;
      if (pe_req_valid && !pe_req_ready) lock_idx <= winner;
      if (spurious) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!spurious)
        else $warning("alu_pe_share_arbiter: PE response with no outstanding tag, dropped");
    end
  end

endmodule

// File: tb/tb_alu_pe_share_arbiter.sv
// Directed bench for alu_pe_share_arbiter: reset, round-robin, lock,
// credit limit, ordering, response backpressure, spurious response, reset.
module tb_alu_pe_share_arbiter;

  localparam int unsigned NUM_REQS     = 4;
  localparam int unsigned REQ_DATAW    = 128;
  localparam int unsigned RSP_DATAW    = 64;
  localparam int unsigned MAX_INFLIGHT = 4;

  logic                              clk = 1'b0;
  logic                              reset_n;
  logic [NUM_REQS-1:0]               req_valid;
  logic [NUM_REQS*REQ_DATAW-1:0]     req_data;
  logic [NUM_REQS-1:0]               req_ready;
  logic                              pe_req_valid;
  logic [REQ_DATAW-1:0]              pe_req_data;
  logic                              pe_req_ready;
  logic                              pe_rsp_valid;
  logic [RSP_DATAW-1:0]              pe_rsp_data;
  logic                              pe_rsp_ready;
  logic [NUM_REQS-1:0]               rsp_valid;
  logic [RSP_DATAW-1:0]              rsp_data;
  logic [NUM_REQS-1:0]               rsp_ready;
  logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight;
  logic                              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pe_share_arbiter #(
    .NUM_REQS     (NUM_REQS),
    .REQ_DATAW    (REQ_DATAW),
    .RSP_DATAW    (RSP_DATAW),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .pe_req_valid (pe_req_valid),
    .pe_req_data  (pe_req_data),
    .pe_req_ready (pe_req_ready),
    .pe_rsp_valid (pe_rsp_valid),
    .pe_rsp_data  (pe_rsp_data),
    .pe_rsp_ready (pe_rsp_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .inflight     (inflight),
    .err          (err)
  );

  function automatic logic [127:0] pay(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {w, w, w, w};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int order_drain [4] = '{2, 3, 0, 1};
  int order_issue [4] = '{3, 1, 1, 0};

  initial begin
    for (int i = 0; i < NUM_REQS; i++) req_data[i*REQ_DATAW +: REQ_DATAW] = pay(i);
    reset_n      = 1'b0;
    req_valid    = 4'hF;
    pe_req_ready = 1'b1;
    pe_rsp_valid = 1'b1;
    pe_rsp_data  = '0;
    rsp_ready    = 4'hF;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_pe_req_valid", pe_req_valid, 0);
    chk("rst_pe_rsp_ready", pe_rsp_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    tick();
    reset_n = 1'b1; req_valid = '0; pe_rsp_valid = 1'b0;
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    tick();

    // Round-robin with immediate responses
    req_valid = 4'hF; pe_req_ready = 1'b1; rsp_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      pe_rsp_valid = (k > 0);
      pe_rsp_data  = 64'(k);
      #1;
      chk("rr_grant", pe_req_data, pay(k % 4));
      chk("rr_ready", req_ready, 1 << (k % 4));
      chk("rr_inflight", inflight, (k > 0) ? 1 : 0);
      if (k > 0) chk("rr_rsp_valid", rsp_valid, 1 << ((k - 1) % 4));
      tick();
    end
    req_valid = '0; pe_rsp_valid = 1'b1;
    #1;
    chk("rr_last_rsp", rsp_valid, 4'b1000);
    tick();
    pe_rsp_valid = 1'b0;
    #1;
    chk("rr_drained", inflight, 0);

    // Lock: requester 2 stalled, requester 0 arrives and must not preempt
    req_valid = 4'b0100; pe_req_ready = 1'b0;
    #1;
    chk("lock_c0_data", pe_req_data, pay(2));
    chk("lock_c0_valid", pe_req_valid, 1);
    chk("lock_c0_ready", req_ready, 0);
    tick();
    req_valid = 4'b0101;
    #1;
    chk("lock_c1_data", pe_req_data, pay(2));
    tick();
    #1;
    chk("lock_c2_data", pe_req_data, pay(2));
    tick();
    pe_req_ready = 1'b1;
    #1;
    chk("lock_c3_data", pe_req_data, pay(2));
    chk("lock_c3_ready", req_ready, 4'b0100);
    tick();
    #1;
    chk("lock_next_grant", req_ready, 4'b0001);
    chk("lock_next_data", pe_req_data, pay(0));
    tick();
    req_valid = '0; pe_rsp_valid = 1'b1;
    #1;
    chk("lock_rsp0", rsp_valid, 4'b0100);
    tick();
    #1;
    chk("lock_rsp1", rsp_valid, 4'b0001);
    tick();
    pe_rsp_valid = 1'b0;

    // Credit limit: rr_ptr is 1 here
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("credit_grant", req_ready, 1 << ((1 + k) % 4));
      tick();
    end
    #1;
    chk("credit_inflight", inflight, 4);
    chk("credit_blocked", pe_req_valid, 0);
    chk("credit_no_ready", req_ready, 0);
    tick();
    pe_rsp_valid = 1'b1; pe_rsp_data = 64'hAA;
    #1;
    chk("credit_pop_blocked", pe_req_valid, 0);
    chk("credit_pop_rsp", rsp_valid, 4'b0010);
    chk("credit_pop_rdy", pe_rsp_ready, 1);
    tick();
    pe_rsp_valid = 1'b0;
    #1;
    chk("credit_after_pop", inflight, 3);
    chk("credit_reissue", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      pe_rsp_valid = 1'b1;
      #1;
      chk("credit_drain", rsp_valid, 1 << order_drain[j]);
      tick();
    end
    pe_rsp_valid = 1'b0;
    #1;
    chk("credit_empty", inflight, 0);

    // Ordering and response backpressure: rr_ptr is 2 here
    for (int j = 0; j < 4; j++) begin
      req_valid = 4'(1 << order_issue[j]);
      #1;
      chk("ord_issue", req_ready, 1 << order_issue[j]);
      tick();
    end
    req_valid = '0;
    pe_rsp_valid = 1'b1; pe_rsp_data = 64'h11;
    #1;
    chk("ord_rsp0_valid", rsp_valid, 4'b1000);
    chk("ord_rsp0_data", rsp_data, 64'h11);
    tick();
    pe_rsp_data = 64'h22; rsp_ready = 4'b1101;
    for (int j = 0; j < 2; j++) begin
      #1;
      chk("bp_pe_rsp_ready", pe_rsp_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_inflight", inflight, 3);
      tick();
    end
    rsp_ready = 4'hF;
    #1;
    chk("ord_rsp1_valid", rsp_valid, 4'b0010);
    chk("ord_rsp1_data", rsp_data, 64'h22);
    chk("ord_rsp1_ready", pe_rsp_ready, 1);
    tick();
    pe_rsp_data = 64'h33;
    #1;
    chk("ord_rsp2_valid", rsp_valid, 4'b0010);
    tick();
    pe_rsp_data = 64'h44;
    #1;
    chk("ord_rsp3_valid", rsp_valid, 4'b0001);
    chk("ord_rsp3_data", rsp_data, 64'h44);
    tick();
    pe_rsp_valid = 1'b0;
    #1;
    chk("ord_empty", inflight, 0);

    // Spurious response
    pe_rsp_valid = 1'b1; pe_rsp_data = 64'hDEAD;
    #1;
    chk("spur_ready", pe_rsp_ready, 1);
    chk("spur_rsp_valid", rsp_valid, 0);
    tick();
    pe_rsp_valid = 1'b0;
    #1;
    chk("spur_err", err, 1);
    chk("spur_inflight", inflight, 0);
    tick();
    #1;
    chk("spur_err_sticky", err, 1);

    // Reset with 3 in flight: rr_ptr is 1 here, grants 1,2,0
    req_valid = 4'b0111;
    tick(); tick(); tick();
    req_valid = '0;
    #1;
    chk("mid_inflight", inflight, 3);
    reset_n = 1'b0; req_valid = 4'hF; pe_rsp_valid = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_pe_req_valid", pe_req_valid, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_pe_rsp_ready", pe_rsp_ready, 0);
    tick();
    reset_n = 1'b1; pe_rsp_valid = 1'b0; pe_req_ready = 1'b0;
    #1;
    chk("post_rst_inflight", inflight, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_rr_ptr", pe_req_data, pay(0));
    tick();
    req_valid = '0; pe_rsp_valid = 1'b1;
    tick();
    pe_rsp_valid = 1'b0;
    #1;
    chk("stale_rsp_err", err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pe_share_arbiter.md
# alu_pe_share_arbiter

- Shares one pipelined, in-order ALU processing element (dot8 or mul/div) between several requesters, e.g. ALU blocks or PE-switch ports that would otherwise each need their own copy.
- Arbitrates requests round-robin with grant locking, and limits outstanding operations with a credit count.
- Records which requester owns each in-flight operation in a tag FIFO, and routes each PE response back to that owner.
- Sits between the per-block PE switches and the single shared PE instance inside the ALU unit.

## Interface
Parameters:
- NUM_REQS, 4, number of requesters (≥2)
- REQ_DATAW, 128, request payload width
- RSP_DATAW, 64, response payload width
- MAX_INFLIGHT, 4, maximum outstanding PE operations (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  NUM_REQS  per-requester request valid
- req_data  in  NUM_REQS*REQ_DATAW  request payloads; requester i occupies slice [i*REQ_DATAW +: REQ_DATAW]
- req_ready  out  NUM_REQS  per-requester accept
- pe_req_valid  out  1  request to shared PE
- pe_req_data  out  REQ_DATAW  granted payload
- pe_req_ready  in  1  PE accepts
- pe_rsp_valid  in  1  PE result valid
- pe_rsp_data  in  RSP_DATAW  PE result
- pe_rsp_ready  out  1  result consumed
- rsp_valid  out  NUM_REQS  per-requester result valid
- rsp_data  out  RSP_DATAW  result payload, broadcast to all requesters
- rsp_ready  in  NUM_REQS  per-requester result accept
- inflight  out  CLOG2(MAX_INFLIGHT+1)  outstanding operation count
- err  out  1  sticky protocol-error flag

## Operation
- A handshake fires when valid and ready are both high in the same cycle.
- **Eligibility.** Requester i is eligible when req_valid[i]=1. Issue is allowed only when inflight < MAX_INFLIGHT.
- **Grant.** Round-robin search starts at rr_ptr:
  - The first eligible index wins.
  - pe_req_valid = any eligible && issue allowed.
  - pe_req_data = winner's slice.
  - req_ready[winner] = pe_req_ready && issue allowed; every other req_ready bit is 0.
- **Lock.** If pe_req_valid=1 and pe_req_ready=0, the winner is registered (locked) and stays granted on following cycles until it fires. Higher-priority arrivals cannot preempt it. A locked requester must hold req_valid.
- **Pointer.** On a request fire, rr_ptr becomes winner+1, wrapping to 0 after NUM_REQS-1. Without a fire, rr_ptr holds.
- **Tag FIFO.**
  - The winner index is pushed on every pe_req fire.
  - The head is popped on every pe_rsp fire.
  - Depth is MAX_INFLIGHT; inflight equals the FIFO occupancy.
- **Response routing.**
  - rsp_valid[head] = pe_rsp_valid; every other rsp_valid bit is 0.
  - rsp_data = pe_rsp_data.
  - pe_rsp_ready = rsp_ready[head].
- **Simultaneous push and pop.** inflight is unchanged.
- **Full boundary.** At inflight == MAX_INFLIGHT, issue is blocked even if a pop occurs in the same cycle. This costs a deliberate one-cycle bubble and keeps ready off the response path.
- **Spurious response.** pe_rsp_valid=1 with an empty FIFO:
  - pe_rsp_ready=1, so the response is dropped.
  - All rsp_valid bits stay 0.
  - err is set and stays set until reset.
  - A simulation assertion fires.
- **Reset** (reset_n=0 sampled at a rising edge):
  - FIFO emptied, inflight=0, rr_ptr=0, lock cleared, err=0.
  - While reset_n=0: all req_ready, rsp_valid, pe_req_valid and pe_rsp_ready outputs are 0.
  - Reset mid-operation discards every tag. The PE must be reset in the same cycle; stale responses after reset set err.

## Timing
- Request path is combinational, zero latency: req_valid → pe_req_valid in the same cycle.
- Throughput is one issue per cycle while below MAX_INFLIGHT.
- Response path is combinational: pe_rsp_valid → rsp_valid[head] in the same cycle. The block adds no response latency.
- Registered state: rr_ptr, lock valid and index, FIFO storage and pointers, inflight, err.
- No combinational path from pe_req_ready to pe_req_valid, or from rsp_ready to rsp_valid.

## Structure
- Shared constants/typedefs go in VX_gpu_pkg: a requester-index type sized CLOG2(NUM_REQS) and a localparam for the default MAX_INFLIGHT.
- Sub-module alu_pe_tag_fifo: synchronous FIFO of requester indices.
  - Ports: push, pop, head, full, empty, count.
  - Behaviour: first-word fall-through.
  - Reset: same synchronous active-low reset_n as this block.
- Round-robin search and lock stay in the top level. The lock makes the stock arbiter unsuitable.

## Test plan
- **Round-robin.** req_valid=4'b1111 held for 8 cycles, pe_req_ready=1, responses returned immediately → grants 0,1,2,3,0,1,2,3; inflight never exceeds 1.
- **Lock.** req 2 pending, pe_req_ready=0 for 3 cycles, req 0 raised at cycle 1 → pe_req_data stays req 2's slice; req 2 fires at cycle 3; next grant is 0.
- **Credit limit.** MAX_INFLIGHT=4, pe_rsp_valid=0, all requesters valid → exactly 4 fires, inflight=4, pe_req_valid=0 afterwards. Then one response in a cycle with a request pending → no issue that cycle; issue on the next cycle.
- **Ordering.** Issue order 3,1,1,0, then 4 responses with rsp_ready=all 1 → rsp_valid asserts in bits 3,1,1,0 order; rsp_data matches the PE order.
- **Backpressure.** Head owner 1 holds rsp_ready[1]=0 for 2 cycles → pe_rsp_ready=0; inflight held; no other rsp_valid bits asserted.
- **Spurious response and reset.** pe_rsp_valid=1 with inflight=0 → err=1, response dropped. reset_n=0 for 1 cycle with 3 in flight → inflight=0, err=0, rr_ptr=0.
